instr_loader: RTL and testbench

- Writer side of the instruction-memory interface. It receives a program image as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Each assembled word is written into instruction memory through a one-word-per-cycle write port.
- The processor is held in reset while a load is in progress. After a load completes with a good checksum, the processor is released and the start PC is supplied to it.

---
 rtl/instr_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them to instruction memory.
// Each write lands the cycle after a word's 4th byte. Full-rate bytes never stall. in_ready drops outside a load.
module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              go,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              proc_reset,
  output logic [31:0]       start_pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, CHECK, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              proc_reset_q, proc_reset_d;
  logic [31:0]       start_pc_q, start_pc_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
  logic [ADDR_W-1:0] base_new;

  assign busy       = (state_q == ADDR) || (state_q == CNT) ||
                      (state_q == DATA) || (state_q == CHECK);
  assign in_ready   = busy;
  assign accept     = in_valid && in_ready;
  assign base_new   = ADDR_W'({hdr_q, in_data});
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign proc_reset = proc_reset_q;
  assign start_pc   = start_pc_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hdr_d        = hdr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    word_idx_d   = word_idx_q;
    word_d       = word_q;
    xor_d        = xor_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    proc_reset_d = proc_reset_q;
    start_pc_d   = start_pc_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (go) begin
          state_d      = ADDR;
          proc_reset_d = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          byte_cnt_d   = 2'd0;
          xor_d        = 8'h00;
        end
      end
      ADDR: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            hdr_d      = in_data;
            byte_cnt_d = 2'd1;
          end else begin
            base_d     = base_new;
            start_pc_d = 32'({base_new, 2'b00});
            byte_cnt_d = 2'd0;
            state_d    = CNT;
          end
        end
      end
      CNT: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            hdr_d      = in_data;
            byte_cnt_d = 2'd1;
          end else begin
            cnt_d      = CNT_W'({hdr_q, in_data});
            word_idx_d = '0;
            byte_cnt_d = 2'd0;
            state_d    = ({hdr_q, in_data} == 16'h0000) ? CHECK : DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = {word_q[15:0], in_data};
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // 4th byte: issue the write next cycle straight from the shift register
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {word_q, in_data};
            wr_addr_d  = base_q + ADDR_W'(word_idx_q);
            word_idx_d = word_idx_q + CNT_W'(1);
            if (word_idx_q == cnt_q - CNT_W'(1)) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d      = DONE;
            done_d       = 1'b1;
            proc_reset_d = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      hdr_q        <= 8'h00;
      base_q       <= '0;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      word_q       <= 24'h0;
      xor_q        <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'h0;
      proc_reset_q <= 1'b1;
      start_pc_q   <= 32'h0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      hdr_q        <= hdr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      word_idx_q   <= word_idx_d;
      word_q       <= word_d;
      xor_q        <= xor_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      proc_reset_q <= proc_reset_d;
      start_pc_q   <= start_pc_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a stream-level model predicts writes, start_pc and pass/fail.
module tb_instr_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        go;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        proc_reset;
  logic [31:0] start_pc;
  logic        busy;
  logic        done;
  logic        error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] words_q[$];
  logic [7:0]  stream_q[$];
  logic [39:0] got_q[$];

  instr_loader #(.ADDR_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .proc_reset(proc_reset), .start_pc(start_pc), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_proc_reset"}, proc_reset, 1);
    chk({tag, "_start_pc"}, start_pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Stream image from the format rules: base, count, payload, XOR checksum (optionally corrupted)
  task automatic build(input logic [15:0] base, input logic [7:0] bad);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(words_q.size());
    stream_q = {};
    stream_q.push_back(base[15:8]);
    stream_q.push_back(base[7:0]);
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    foreach (words_q[i]) begin
      for (int b = 3; b >= 0; b--) begin
        stream_q.push_back(words_q[i][b*8 +: 8]);
        x = x ^ words_q[i][b*8 +: 8];
      end
    end
    stream_q.push_back(x ^ bad);
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random gaps
  task automatic send(input int nbytes, input int mode, input bit noise);
    int idx = 0;
    int cyc = 0;
    while (idx < nbytes && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
      go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        1:       in_valid = (cyc % 2 == 0);
        2:       in_valid = ($urandom_range(0, 2) != 0);
        default: in_valid = 1'b1;
      endcase
      in_data = in_valid ? stream_q[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    go = 1'b0;
    if (idx < nbytes) chk("send_timeout", 64'(idx), 64'(nbytes));
  endtask

  task automatic pulse_go();
    @(negedge CLK);
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    in_valid = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_proc_reset", proc_reset, 1);
    chk("go_done_clr", done, 0);
    chk("go_error_clr", error, 0);
  endtask

  task automatic run_load(input string tag, input logic [15:0] base, input logic [7:0] bad,
                          input int mode, input bit noise, input bit prevalid);
    logic [7:0] a;
    bit ok;
    build(base, bad);
    got_q = {};
    if (prevalid) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data = stream_q[0];
      repeat (3) @(negedge CLK);
      chk({tag, "_idle_ready"}, in_ready, 0);
    end
    pulse_go();
    send(stream_q.size(), mode, noise);
    repeat (2) @(negedge CLK);
    ok = (bad == 8'h00);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(words_q.size()));
    foreach (words_q[i]) begin
      a = base[7:0] + 8'(i);
      if (i < got_q.size()) chk({tag, "_wr"}, got_q[i], {a, words_q[i]});
    end
    chk({tag, "_done"}, done, ok);
    chk({tag, "_error"}, error, !ok);
    chk({tag, "_proc_reset"}, proc_reset, !ok);
    chk({tag, "_start_pc"}, start_pc, {22'h0, base[7:0], 2'b00});
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    RESET = 1'b1;
    go = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");
    RESET = 1'b0;

    words_q = '{32'hDEADBEEF, 32'h01234567};
    run_load("basic", 16'h0010, 8'h00, 0, 1'b0, 1'b0);
    run_load("badck", 16'h0010, 8'h01, 0, 1'b0, 1'b0);
    run_load("recov", 16'h0010, 8'h00, 0, 1'b0, 1'b0);

    words_q = {};
    run_load("n0", 16'h0005, 8'h00, 0, 1'b0, 1'b0);
    run_load("n0bad", 16'h0005, 8'h01, 0, 1'b0, 1'b0);

    words_q = '{32'hCAFEF00D, 32'h12345678};
    run_load("wrap", 16'h00FF, 8'h00, 0, 1'b0, 1'b0);
    run_load("hibits", 16'h1234, 8'h00, 0, 1'b0, 1'b0);

    words_q = '{32'hDEADBEEF, 32'h01234567};
    run_load("slow", 16'h0010, 8'h00, 1, 1'b0, 1'b1);

    for (int t = 0; t < 10; t++) begin
      words_q = {};
      for (int w = 0; w < int'($urandom_range(0, 6)); w++) words_q.push_back($urandom);
      run_load("rnd", 16'($urandom), ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    words_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    build(16'h0020, 8'h00);
    got_q = {};
    pulse_go();
    send(4 + 5, 0, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_vals("midrst");
    chk("midrst_nwr", 64'(got_q.size()), 1);
    RESET = 1'b0;
    run_load("after_rst", 16'h0020, 8'h00, 2, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
